// File: rtl/lane_deskew_buffer.sv
// rtl/lane_deskew_buffer.sv - multi-lane COM-based deskew buffer
// Captures each lane's COM position, then reads all lanes so COM leaves together.
module lane_deskew_buffer #(
  parameter int                         NUM_LANES  = 4,
  parameter int                         DATA_WIDTH = 10,
  parameter int                         DEPTH      = 8,
  parameter int                         MAX_SKEW   = 5,
  parameter logic [DATA_WIDTH-1:0]      COM_RDN    = 10'h0FA,
  parameter logic [DATA_WIDTH-1:0]      COM_RDP    = 10'h305
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
  input  logic                            realign,
  output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
  output logic                            out_valid,
  output logic                            aligned,
  output logic                            deskew_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(MAX_SKEW + 2);

  typedef enum logic {SEARCH, ALIGNED} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [NUM_LANES][DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr  [NUM_LANES];
  logic [AW-1:0]         com_ptr [NUM_LANES];
  logic [NUM_LANES-1:0]  captured;
  logic [SW-1:0]         skew_cnt, skew_nxt;
  logic [DATA_WIDTH-1:0] rd_sym [NUM_LANES];
  logic [NUM_LANES-1:0]  wr_com, rd_com, cap_set;
  logic                  cap_clr, load_rd, rd_adv, ov_nxt, err_nxt;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      rd_sym[i] = mem[i][rd_ptr[i]];
      wr_com[i] = (data_in[i*DATA_WIDTH +: DATA_WIDTH] == COM_RDN) ||
                  (data_in[i*DATA_WIDTH +: DATA_WIDTH] == COM_RDP);
      rd_com[i] = (rd_sym[i] == COM_RDN) || (rd_sym[i] == COM_RDP);
    end
  end

  // Storage is written unconditionally on every valid cycle, whatever the state.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int i = 0; i < NUM_LANES; i++)
        mem[i][wr_ptr] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    skew_nxt  = skew_cnt;
    cap_set   = '0;
    cap_clr   = 1'b0;
    load_rd   = 1'b0;
    rd_adv    = 1'b0;
    ov_nxt    = 1'b0;
    err_nxt   = 1'b0;
    if (realign) begin
      state_nxt = SEARCH;
      cap_clr   = 1'b1;
    end else begin
      case (state)
        SEARCH: begin
          if (in_valid) begin
            if ((|captured) && (skew_cnt >= SW'(MAX_SKEW))) begin
              err_nxt = 1'b1;
              cap_clr = 1'b1;
            end else begin
              cap_set  = wr_com & ~captured;
              skew_nxt = (|captured) ? skew_cnt + 1'b1 : '0;
              // Completing lane is captured this edge, so alignment can start next cycle.
              if (&(captured | cap_set)) begin
                state_nxt = ALIGNED;
                load_rd   = 1'b1;
              end
            end
          end
        end
        ALIGNED: begin
          if (in_valid) begin
            rd_adv = 1'b1;
            ov_nxt = 1'b1;
            if ((|rd_com) && !(&rd_com)) begin
              err_nxt   = 1'b1;
              state_nxt = SEARCH;
              cap_clr   = 1'b1;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SEARCH;
      wr_ptr       <= '0;
      captured     <= '0;
      skew_cnt     <= '0;
      data_out     <= '0;
      out_valid    <= 1'b0;
      deskew_error <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        rd_ptr[i]  <= '0;
        com_ptr[i] <= '0;
      end
    end else begin
      state        <= state_nxt;
      skew_cnt     <= skew_nxt;
      out_valid    <= ov_nxt;
      deskew_error <= err_nxt;
      if (in_valid)
        wr_ptr <= wr_ptr + 1'b1;
      if (cap_clr)
        captured <= '0;
      else
        captured <= captured | cap_set;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (cap_set[i])
          com_ptr[i] <= wr_ptr;
        if (load_rd)
          rd_ptr[i] <= cap_set[i] ? wr_ptr : com_ptr[i];
        else if (rd_adv)
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (rd_adv)
          data_out[i*DATA_WIDTH +: DATA_WIDTH] <= rd_sym[i];
      end
    end
  end

  assign aligned = (state == ALIGNED);

endmodule
